// File: rtl/aer_frame_decoder.sv
// aer_frame_decoder: four-phase five-rail AER frame decoder with multicast, error recovery and event count
module aer_frame_decoder #(
  parameter int ADDR_W = 2,
  parameter int NUM_CH = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_W = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Fs,
  input  logic              X0,
  input  logic              Zero,
  input  logic              One,
  input  logic              Fe,
  output logic              Fs_ack,
  output logic              X0_ack,
  output logic              Zero_ack,
  output logic              One_ack,
  output logic              Fe_ack,
  output logic [NUM_CH-1:0] ch_up,
  output logic [NUM_CH-1:0] ch_down,
  output logic              frame_err,
  output logic              busy,
  output logic [15:0]       event_cnt
);
  localparam int CW = $clog2(ADDR_W + 1);
  typedef enum logic [2:0] {WAIT_LOW, IDLE, ADDR, POL, END} state_t;
  state_t state;
  logic [4:0] sync [SYNC_STAGES];
  logic [4:0] r, ack;
  logic present, multi, pol;
  logic [ADDR_W-1:0] val, wild;
  logic [CW-1:0] cnt;
  logic [7:0] pcnt;
  logic [NUM_CH-1:0] match;
  assign r = sync[SYNC_STAGES-1];
  assign {Fe_ack, One_ack, Zero_ack, X0_ack, Fs_ack} = ack;
  assign present = (r != 5'd0) && (ack == 5'd0) && (state != WAIT_LOW);
  assign multi = (r & (r - 5'd1)) != 5'd0;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_match
    assign match[i] = ~|((val ^ ADDR_W'(i)) & ~wild);
  end
  always_ff @(posedge clk) begin
    sync[0] <= {Fe, One, Zero, X0, Fs};
    for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT_LOW;
      ack <= '0;
      ch_up <= '0;
      ch_down <= '0;
      frame_err <= 1'b0;
      busy <= 1'b0;
      event_cnt <= '0;
      val <= '0;
      wild <= '0;
      cnt <= '0;
      pol <= 1'b0;
      pcnt <= '0;
    end else begin
      frame_err <= 1'b0;
      if (pcnt != 8'd0) pcnt <= pcnt - 8'd1;
      else begin
        ch_up <= '0;
        ch_down <= '0;
      end
      if (ack != 5'd0 && r == 5'd0) ack <= '0;
      if (state == WAIT_LOW) begin
        if (r == 5'd0) state <= IDLE;
      end else if (present) begin
        ack <= r;
        if (multi) begin
          frame_err <= 1'b1;
          state <= IDLE;
          busy <= 1'b0;
        end else if (r[0]) begin
          frame_err <= state != IDLE;
          state <= ADDR;
          busy <= 1'b1;
          cnt <= '0;
          val <= '0;
          wild <= '0;
        end else if (state == ADDR && !r[4]) begin
          val <= ADDR_W'({val, r[3]});
          wild <= ADDR_W'({wild, r[1]});
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ADDR_W - 1)) state <= POL;
        end else if (state == POL && (r[2] || r[3])) begin
          pol <= r[3];
          state <= END;
        end else if (state == END && r[4]) begin
          ch_up <= pol ? match : '0;
          ch_down <= pol ? '0 : match;
          pcnt <= 8'(PULSE_W - 1);
          event_cnt <= event_cnt + 16'd1;
          state <= IDLE;
          busy <= 1'b0;
        end else begin
          frame_err <= 1'b1;
          state <= IDLE;
          busy <= 1'b0;
        end
      end
    end
  end
endmodule
